instctrl_unit: RTL and testbench
================================

INSTCTRL_UNIT -- requirements
Module: instctrl

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: system clock; all state changes on its rising edge except reset.
REQ-003 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 Port dataIn, input, 8 bits: data bus value carrying the opcode during a fetch.
REQ-005 Port irq, input, 1 bit: interrupt request, active-high level, sampled on clk rising edges.
REQ-006 Port iCyc, input, 1 bit: advance the cycle counter by one.
REQ-007 Port rCyc, input, 1 bit: end of instruction; clear the cycle counter.
REQ-008 Port sCyc, input, 1 bit: opcode-fetch (sync) cycle; load the instruction register.
REQ-009 Port ir, output, 8 bits: instruction register, registered.
REQ-010 Port cycle, output, 3 bits: current instruction T-state, registered.

Function
REQ-011 Internal 1-bit irq_pending flag: set on any clk edge with irq=1; cleared only as stated in REQ-014 or by reset.
REQ-012 Control priority per clk edge: rCyc > sCyc > iCyc; one action per edge.
REQ-013 rCyc=1: cycle <= 0; ir holds.
REQ-014 sCyc=1 with rCyc=0:
- if irq_pending=1 or irq=1: ir <= 8'h00 (BRK injection) and irq_pending <= 0.
- otherwise: ir <= dataIn.
- In both cases: cycle <= 1.
REQ-015 iCyc=1 with rCyc=0 and sCyc=0: cycle <= cycle+1, saturating at 7 (7 holds at 7).
REQ-016 No control asserted: ir and cycle hold.
REQ-017 irq asserted on the same edge as sCyc is consumed by that fetch; pending is not left set afterwards.
REQ-018 irq asserted on the same edge as rCyc or iCyc: pending sets; the counter action proceeds normally.
REQ-019 Outputs ir and cycle SHALL change only on a clk rising edge or on reset assertion; no combinational path from inputs to outputs.
REQ-020 Latency: every control or data input affects the outputs exactly one clk edge after it is sampled.

Reset
REQ-021 rst=0 SHALL immediately, without a clock, force ir=8'h00, cycle=3'd0 and irq_pending=0.
REQ-022 While rst=0, all inputs SHALL be ignored.
REQ-023 Normal operation SHALL resume on the first clk rising edge after rst returns to 1.
REQ-024 Reset asserted mid-instruction SHALL discard any pending interrupt.

Verification
REQ-025 Reset: drive rst=0 between clock edges -> ir=00 and cycle=0 at once; release, dataIn=43, no controls for 2 edges -> ir=00, cycle=0.
REQ-026 Fetch and count: sCyc=1 with dataIn=43 for 1 edge -> ir=43, cycle=1; then iCyc=1 for 2 edges -> cycle=3; then rCyc=1 for 1 edge -> cycle=0, ir=43.
REQ-027 Saturation: starting from cycle=1, iCyc=1 for 8 edges -> cycle reaches 7 and stays at 7.
REQ-028 Interrupt injection: irq=1 for 1 edge with no other controls, then sCyc=1 with dataIn=A9 -> ir=00, cycle=1. A following sCyc with dataIn=A9 -> ir=A9, proving pending was cleared.
REQ-029 Priority: rCyc=1, sCyc=1 and iCyc=1 together on one edge with dataIn=55 -> cycle=0 and ir unchanged. sCyc=1 and iCyc=1 together -> ir=55, cycle=1.
REQ-030 Reset mid-operation: set irq pending and reach cycle=3, pulse rst=0, then sCyc=1 with dataIn=43 -> ir=43, not 00.

Source files
------------

// File: rtl/instctrl_unit.sv
// Instruction control: fetches the opcode into ir, tracks the T-state counter
// and injects BRK (8'h00) on the next fetch whenever an interrupt is pending.
module instctrl_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dataIn,
   input  logic       irq,
   input  logic       iCyc,
   input  logic       rCyc,
   input  logic       sCyc,
   output logic [7:0] ir,
   output logic [2:0] cycle
);

   logic [7:0] ir_q, ir_d;
   logic [2:0] cycle_q, cycle_d;
   logic       irq_pending_q, irq_pending_d;
   logic       fetch;

   // A fetch consumes the interrupt, including one arriving on that same edge.
   assign fetch = sCyc & ~rCyc;

   always_comb begin
      ir_d          = ir_q;
      cycle_d       = cycle_q;
      irq_pending_d = fetch ? 1'b0 : (irq_pending_q | irq);
      if (rCyc) begin
         cycle_d = 3'd0;
      end else if (sCyc) begin
         ir_d    = (irq_pending_q | irq) ? 8'h00 : dataIn;
         cycle_d = 3'd1;
      end else if (iCyc) begin
         cycle_d = (cycle_q == 3'd7) ? 3'd7 : cycle_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_q          <= 8'h00;
         cycle_q       <= 3'd0;
         irq_pending_q <= 1'b0;
      end else begin
         ir_q          <= ir_d;
         cycle_q       <= cycle_d;
         irq_pending_q <= irq_pending_d;
      end
   end

   assign ir    = ir_q;
   assign cycle = cycle_q;

endmodule

// File: tb/tb_instctrl_unit.sv
// Scoreboard bench for instctrl_unit: a behavioural model pushes the expected
// {ir, cycle} per edge; each test pops and compares after the edge.
module tb_instctrl_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dataIn = 8'h00;
   logic       irq = 1'b0, iCyc = 1'b0, rCyc = 1'b0, sCyc = 1'b0;
   logic [7:0] ir;
   logic [2:0] cycle;

   int checks = 0;
   int passes = 0;

   logic [10:0] sb[$];
   logic [10:0] exp_v;
   logic [7:0]  m_ir;
   logic [2:0]  m_cyc;
   logic        m_pend;

   instctrl_unit dut (
      .clk(clk), .rst(rst), .dataIn(dataIn), .irq(irq),
      .iCyc(iCyc), .rCyc(rCyc), .sCyc(sCyc), .ir(ir), .cycle(cycle)
   );

   always #5 clk = ~clk;

   // Drive one edge worth of inputs, advance the model, push its expectation.
   task automatic drive(input logic r, input logic s, input logic i,
                        input logic q, input logic [7:0] d);
      @(negedge clk);
      rCyc = r; sCyc = s; iCyc = i; irq = q; dataIn = d;
      if (rst) begin
         if (r) m_cyc = 3'd0;
         else if (s) begin
            m_ir  = (m_pend || q) ? 8'h00 : d;
            m_cyc = 3'd1;
         end else if (i) m_cyc = (m_cyc == 3'd7) ? 3'd7 : m_cyc + 3'd1;
         m_pend = (s && !r) ? 1'b0 : (m_pend | q);
      end
      sb.push_back({m_ir, m_cyc});
      @(posedge clk);
      #1;
      rCyc = 0; sCyc = 0; iCyc = 0; irq = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      m_ir = 8'h00; m_cyc = 3'd0; m_pend = 1'b0;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 8'h00);
      void'(sb.pop_front());
      apply_reset();
      #1;
      checks++;
      if ({ir, cycle} !== 11'h000)
         $display("FAIL reset_async: ir=%h cycle=%0d want ir=00 cycle=0", ir, cycle);
      else passes++;
      // Inputs are ignored while held in reset.
      drive(0, 1, 0, 1, 8'h43);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h00)
         $display("FAIL reset_hold: ir=%h cycle=%0d want ir=00 cycle=0", ir, cycle);
      else passes++;
      @(negedge clk) rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 0, 8'h43);
         exp_v = sb.pop_front();
         checks++;
         if ({ir, cycle} !== exp_v || {ir, cycle} !== 11'h000)
            $display("FAIL reset_idle%0d: ir=%h cycle=%0d want ir=00 cycle=0", k, ir, cycle);
         else passes++;
      end
   endtask

   task automatic test_fetch_count();
      drive(0, 1, 0, 0, 8'h43);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h43 || cycle !== 3'd1)
         $display("FAIL fetch: ir=%h cycle=%0d want ir=43 cycle=1", ir, cycle);
      else passes++;
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 1, 0, 8'h00);
         exp_v = sb.pop_front();
         checks++;
         if ({ir, cycle} !== exp_v)
            $display("FAIL count%0d: ir=%h cycle=%0d want ir=%h cycle=%0d", k, ir, cycle, exp_v[10:3], exp_v[2:0]);
         else passes++;
      end
      checks++;
      if (cycle !== 3'd3) $display("FAIL count_total: cycle=%0d want 3", cycle);
      else passes++;
      drive(1, 0, 0, 0, 8'h00);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h43 || cycle !== 3'd0)
         $display("FAIL end_instr: ir=%h cycle=%0d want ir=43 cycle=0", ir, cycle);
      else passes++;
   endtask

   task automatic test_saturation();
      drive(0, 1, 0, 0, 8'h12);
      void'(sb.pop_front());
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 1, 0, 8'h00);
         exp_v = sb.pop_front();
         checks++;
         if ({ir, cycle} !== exp_v)
            $display("FAIL sat_step%0d: cycle=%0d want %0d", k, cycle, exp_v[2:0]);
         else passes++;
      end
      checks++;
      if (cycle !== 3'd7) $display("FAIL sat_final: cycle=%0d want 7", cycle);
      else passes++;
   endtask

   task automatic test_irq_inject();
      drive(0, 0, 0, 1, 8'h00);
      void'(sb.pop_front());
      drive(0, 1, 0, 0, 8'hA9);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h00 || cycle !== 3'd1)
         $display("FAIL brk_inject: ir=%h cycle=%0d want ir=00 cycle=1", ir, cycle);
      else passes++;
      drive(0, 1, 0, 0, 8'hA9);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'hA9)
         $display("FAIL pend_cleared: ir=%h want A9", ir);
      else passes++;
      // irq on the fetch edge is consumed there, leaving nothing pending.
      drive(0, 1, 0, 1, 8'h77);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h00)
         $display("FAIL irq_same_fetch: ir=%h want 00", ir);
      else passes++;
      drive(0, 1, 0, 0, 8'h77);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h77)
         $display("FAIL irq_same_clr: ir=%h want 77", ir);
      else passes++;
      // irq on an rCyc edge sets pending while the counter still clears.
      drive(1, 0, 0, 1, 8'h00);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || cycle !== 3'd0)
         $display("FAIL irq_rcyc: cycle=%0d want 0", cycle);
      else passes++;
      drive(0, 1, 0, 0, 8'h66);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h00)
         $display("FAIL irq_rcyc_brk: ir=%h want 00", ir);
      else passes++;
   endtask

   task automatic test_priority();
      drive(0, 1, 0, 0, 8'h3C);
      void'(sb.pop_front());
      drive(1, 1, 1, 0, 8'h55);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h3C || cycle !== 3'd0)
         $display("FAIL prio_r: ir=%h cycle=%0d want ir=3c cycle=0", ir, cycle);
      else passes++;
      drive(0, 1, 1, 0, 8'h55);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h55 || cycle !== 3'd1)
         $display("FAIL prio_s: ir=%h cycle=%0d want ir=55 cycle=1", ir, cycle);
      else passes++;
   endtask

   task automatic test_reset_mid();
      drive(0, 1, 0, 0, 8'h21);
      drive(0, 0, 1, 1, 8'h00);
      drive(0, 0, 1, 0, 8'h00);
      repeat (3) void'(sb.pop_front());
      checks++;
      if (cycle !== 3'd3) $display("FAIL mid_setup: cycle=%0d want 3", cycle);
      else passes++;
      apply_reset();
      #1;
      checks++;
      if ({ir, cycle} !== 11'h000)
         $display("FAIL mid_reset: ir=%h cycle=%0d want ir=00 cycle=0", ir, cycle);
      else passes++;
      @(negedge clk) rst = 1'b1;
      drive(0, 1, 0, 0, 8'h43);
      exp_v = sb.pop_front();
      checks++;
      if ({ir, cycle} !== exp_v || ir !== 8'h43)
         $display("FAIL mid_pend_drop: ir=%h want 43", ir);
      else passes++;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 40; k++) begin
         drive(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 6) == 0),
               8'($urandom));
         exp_v = sb.pop_front();
         checks++;
         if ({ir, cycle} !== exp_v)
            $display("FAIL b2b%0d: ir=%h cycle=%0d want ir=%h cycle=%0d", k, ir, cycle, exp_v[10:3], exp_v[2:0]);
         else passes++;
      end
   endtask

   initial begin
      m_ir = 8'hxx; m_cyc = 3'bxxx; m_pend = 1'bx;
      test_reset();
      test_fetch_count();
      test_saturation();
      test_irq_inject();
      test_priority();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
